rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Two-port arbiter that shares the single combinational instruction ROM port between two requesters: port 0 (instruction fetch) and port 1 (debug/monitor readback). It decodes and validates each request address, sequences one ROM read per transaction through a two-state FSM, and returns registered read data with a per-port valid pulse. It sits between the requesters and the ROM's address/data pins, and it owns that port exclusively.

## Interface
- BASE_ADDRESS, 25'd0, value that address[31:7] must equal for a request to hit the 32-word ROM window
- STATS_W, 16, width of the statistics counters (used only when stats are compiled in)
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  read request; the requester holds it and its address stable until it sees gnt
- addr0 / addr1  in  32  byte address for the request
- gnt0 / gnt1  out  1  one-cycle pulse; the request has been accepted
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata and err are valid
- rdata0 / rdata1  out  32  read data, held until the next rvalid on that port
- err0 / err1  out  1  qualifies rvalid; set for an unaligned or out-of-window address
- mem_addr  out  32  address driven to the ROM
- mem_data  in  32  ROM read data, combinational from mem_addr
- busy  out  1  high while the FSM is in READ
- grant_cnt0, grant_cnt1, conflict_cnt  out  STATS_W  present only with ROM_ARB_STATS_EN

## Operation
- FSM states: IDLE and READ.
- IDLE → READ when req0 or req1 is sampled high. Otherwise the FSM stays in IDLE.
- READ → IDLE unconditionally.
- Arbitration is round-robin with a last-winner pointer `lw`. Reset value of lw is 1, so port 0 wins the first conflict.
  - If only one port requests, that port wins.
  - If both request, the port other than lw wins.
  - lw updates only on a grant.
- On the IDLE→READ edge the block latches:
  - the winner id
  - the winner's address into `a_q`
  - `bad`, which is set when a_q[1:0] != 0 or a_q[31:7] != BASE_ADDRESS
- In READ:
  - gnt of the winner is high.
  - mem_addr = a_q.
  - On the READ→IDLE edge, rdata_w <= bad ? 32'h0 : mem_data, and err_w <= bad. The other port's rdata and err are untouched.
- The winner's rvalid is high for the cycle following READ.
- A losing or new request in that same cycle is sampled normally, so back-to-back transactions are gapless at 1 transaction per 2 cycles.
- mem_addr holds its last value in IDLE; it does not toggle without a grant.
- Requests arriving during READ are not sampled until the FSM returns to IDLE.
- A request withdrawn before gnt is legal and is simply not served.
- Reset (asynchronous, any state, including mid-READ): the FSM goes to IDLE. The in-flight transaction is dropped with no rvalid.
- Reset values: all gnt, rvalid and err outputs 0; rdata0/1 = 0; mem_addr = 0; busy = 0; lw = 1; counters 0.

## Timing
- req high at edge k (FSM in IDLE) → gnt and busy high in cycle k..k+1 → rvalid high in cycle k+1..k+2. Request-to-data latency is 2 cycles.
- gnt, rvalid and busy are registered, glitch-free single-cycle pulses.
- gnt0 and gnt1 are never high together; the same holds for rvalid0 and rvalid1.
- mem_data must settle within one cycle of mem_addr.

## Configuration
- ROM_ARB_STATS_EN defined:
  - grant_cnt0 and grant_cnt1 increment on each grant to their port.
  - conflict_cnt increments on each IDLE cycle with req0 && req1.
  - All three counters saturate at all-ones; they do not wrap.
- ROM_ARB_STATS_EN undefined: the counters and their ports are absent, with no other behavioural change.

## Structure
- Package rom_arb_pkg holds:
  - state encodings ST_IDLE = 1'b0, ST_READ = 1'b1
  - port-id constants PORT_FETCH = 0, PORT_DBG = 1
  - the window shift constant ROM_WIN_LSB = 7
- Sub-module rr_arb2 (combinational):
  - inputs: req[1:0], lw
  - output: winner
  - output: any

## Test plan
- Single fetch: reset, then req0 with addr0 = 32'h4 and ROM[1] = 32'h2063_0006 → gnt0 pulse 1 cycle later, rvalid0 2 cycles after req, rdata0 = 32'h2063_0006, err0 = 0.
- Conflict: req0 and req1 held continuously, both at addr 0 → grants alternate 0,1,0,1, one every 2 cycles; with stats compiled in, conflict_cnt counts each IDLE cycle where both request.
- Bad address: req1 with addr1 = 32'h6 → rvalid1 with err1 = 1 and rdata1 = 0. Then addr1 = 32'h80 with BASE_ADDRESS = 0 → err1 = 1.
- Mid-READ reset: assert reset while busy = 1 → all outputs 0 immediately, no rvalid after release; a following req1 is served first, since lw = 1 means port 0 wins only on conflict.
- Saturation: with ROM_ARB_STATS_EN and STATS_W = 4, run 20 grants on port 0 → grant_cnt0 stops at 15.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// rom_arb_pkg: shared encodings and helpers for the ROM port arbiter.
// Optional statistics counters are enabled by defining ROM_ARB_STATS_EN.
package rom_arb_pkg;

    // FSM encoding: one ROM read takes exactly one READ cycle
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // Requester ids as seen by the winner/last-winner registers
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DBG   = 1'b1;

    // The ROM window is 32 words = 128 bytes, so bits above 6 select the window
    localparam int ROM_WIN_LSB = 7;

    // An address is rejected when it is not word aligned or lies outside the window
    function automatic logic addrBad(input logic [31:0] addr,
                                     input logic [31-ROM_WIN_LSB:0] base);
        return (addr[1:0] != 2'b00) || (addr[31:ROM_WIN_LSB] != base);
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick. A lone requester always wins; on a
// conflict the port that did not win last time goes first.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lw,
    output logic       winner,
    output logic       any
);

    // Port 1 wins when it asks alone, or when both ask and port 0 had the last grant
    always_comb begin
        any    = req[0] | req[1];
        winner = PORT_FETCH;
        if (req[1] && (!req[0] || (lw == PORT_FETCH))) begin
            winner = PORT_DBG;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM port between instruction fetch
// (port 0) and debug readback (port 1). One transaction every two cycles:
// IDLE samples and grants, READ drives the ROM and captures its data.
// Define ROM_ARB_STATS_EN to add saturating grant/conflict counters.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [24:0] BASE_ADDRESS = 25'd0,
    parameter int          STATS_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic [31:0]        addr0,
    input  logic [31:0]        addr1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [31:0]        rdata0,
    output logic [31:0]        rdata1,
    output logic               err0,
    output logic               err1,
    output logic [31:0]        mem_addr,
    input  logic [31:0]        mem_data,
    output logic               busy
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] grant_cnt0,
    output logic [STATS_W-1:0] grant_cnt1,
    output logic [STATS_W-1:0] conflict_cnt
`endif
);

    state_t      r_state;
    logic        r_lastWinner;
    logic        r_winner;
    logic        r_bad;
    logic [31:0] r_addrQ;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_err0;
    logic        r_err1;

    logic        w_winner;
    logic        w_any;
    logic [31:0] w_reqAddr;

    rr_arb2 u_rrArb (
        .req    ({req1, req0}),
        .lw     (r_lastWinner),
        .winner (w_winner),
        .any    (w_any)
    );

    // Route the address of whichever port the arbiter is picking this cycle
    always_comb begin
        w_reqAddr = (w_winner == PORT_DBG) ? addr1 : addr0;
    end

    // Main FSM: grant and latch the request in IDLE, return data leaving READ.
    // Pulses default low each cycle so they last exactly one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lastWinner <= PORT_DBG;
            r_winner     <= PORT_FETCH;
            r_bad        <= 1'b0;
            r_addrQ      <= 32'h0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= 32'h0;
            r_rdata1     <= 32'h0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state      <= ST_READ;
                        r_winner     <= w_winner;
                        r_lastWinner <= w_winner;
                        r_addrQ      <= w_reqAddr;
                        r_bad        <= addrBad(w_reqAddr, BASE_ADDRESS);
                        r_gnt0       <= (w_winner == PORT_FETCH);
                        r_gnt1       <= (w_winner == PORT_DBG);
                    end
                end
                ST_READ: begin
                    r_state <= ST_IDLE;
                    if (r_winner == PORT_DBG) begin
                        r_rvalid1 <= 1'b1;
                        r_rdata1  <= r_bad ? 32'h0 : mem_data;
                        r_err1    <= r_bad;
                    end else begin
                        r_rvalid0 <= 1'b1;
                        r_rdata0  <= r_bad ? 32'h0 : mem_data;
                        r_err0    <= r_bad;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign err0     = r_err0;
    assign err1     = r_err1;
    assign mem_addr = r_addrQ;
    assign busy     = (r_state == ST_READ);

`ifdef ROM_ARB_STATS_EN
    logic [STATS_W-1:0] r_grantCnt0;
    logic [STATS_W-1:0] r_grantCnt1;
    logic [STATS_W-1:0] r_conflictCnt;

    // Saturating counters: grants per port and IDLE cycles with both requesting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grantCnt0   <= '0;
            r_grantCnt1   <= '0;
            r_conflictCnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_any && (w_winner == PORT_FETCH) && (r_grantCnt0 != '1)) begin
                r_grantCnt0 <= r_grantCnt0 + STATS_W'(1);
            end
            if (w_any && (w_winner == PORT_DBG) && (r_grantCnt1 != '1)) begin
                r_grantCnt1 <= r_grantCnt1 + STATS_W'(1);
            end
            if (req0 && req1 && (r_conflictCnt != '1)) begin
                r_conflictCnt <= r_conflictCnt + STATS_W'(1);
            end
        end
    end

    assign grant_cnt0   = r_grantCnt0;
    assign grant_cnt1   = r_grantCnt1;
    assign conflict_cnt = r_conflictCnt;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench for rom_arbiter with a read-data scoreboard.
// Counter checks are included when ROM_ARB_STATS_EN is defined.
module tb_rom_arbiter;

    localparam int STATS_W = 4;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_data;
`ifdef ROM_ARB_STATS_EN
    logic [STATS_W-1:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    logic [31:0] rom [32];
    exp_t        sbq [$];
    exp_t        monE;
    int          checks   = 0;
    int          failures = 0;

    rom_arbiter #(.BASE_ADDRESS(25'd0), .STATS_W(STATS_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .err0     (err0),
        .err1     (err1),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy)
`ifdef ROM_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Combinational ROM model on the word index of mem_addr
    assign mem_data = rom[mem_addr[6:2]];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [31:0] a0,
                                 input logic r1, input logic [31:0] a1);
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectRead(input logic port, input logic [31:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sbq.push_back(e);
    endtask

    // Scoreboard monitor: every rvalid must match the oldest expected read
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt0 || gnt1) checkOutput("gntExclusive", 32'(gnt0 & gnt1), 32'h0);
            if (rvalid0 || rvalid1) begin
                checkOutput("rvalidExclusive", 32'(rvalid0 & rvalid1), 32'h0);
                checkOutput("sbUnderflow", 32'(sbq.size() > 0), 32'h1);
                if (sbq.size() > 0) begin
                    monE = sbq.pop_front();
                    checkOutput("sbPort", 32'(rvalid1), 32'(monE.port));
                    checkOutput("sbData", rvalid1 ? rdata1 : rdata0, monE.data);
                    checkOutput("sbErr", 32'(rvalid1 ? err1 : err0), 32'(monE.err));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 + 32'(i * 16);
        rom[1] = 32'h2063_0006;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) tick();

        // Reset values
        checkOutput("rstPulses", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy}), 32'h0);
        checkOutput("rstRdata0", rdata0, 32'h0);
        checkOutput("rstRdata1", rdata1, 32'h0);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        reset = 1'b0;
        tick();

        // Single fetch from word 1
        $display("[TB] single fetch");
        applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
        expectRead(1'b0, 32'h2063_0006, 1'b0);
        tick();
        checkOutput("fetchGnt0", 32'(gnt0), 32'h1);
        checkOutput("fetchGnt1", 32'(gnt1), 32'h0);
        checkOutput("fetchBusy", 32'(busy), 32'h1);
        checkOutput("fetchMemAddr", mem_addr, 32'h4);
        checkOutput("fetchEarlyRvalid", 32'(rvalid0), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("fetchRvalid0", 32'(rvalid0), 32'h1);
        checkOutput("fetchRdata0", rdata0, 32'h2063_0006);
        checkOutput("fetchErr0", 32'(err0), 32'h0);
        checkOutput("fetchGntDone", 32'(gnt0), 32'h0);
        checkOutput("fetchBusyDone", 32'(busy), 32'h0);
        tick();
        checkOutput("fetchRvalidPulse", 32'(rvalid0), 32'h0);
        checkOutput("fetchRdataHeld", rdata0, 32'h2063_0006);
        checkOutput("memAddrHeld", mem_addr, 32'h4);

        // Conflict from a fresh reset: grants alternate 0,1,0,1
        $display("[TB] conflict");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            expectRead(1'(i % 2), rom[0], 1'b0);
            tick();
            checkOutput("conflictGnt0", 32'(gnt0), 32'((i % 2) == 0));
            checkOutput("conflictGnt1", 32'(gnt1), 32'((i % 2) == 1));
            tick();
            checkOutput("conflictGap", 32'(gnt0 | gnt1), 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
`ifdef ROM_ARB_STATS_EN
        checkOutput("conflictCnt", 32'(conflict_cnt), 32'd4);
        checkOutput("grantCnt0", 32'(grant_cnt0), 32'd2);
        checkOutput("grantCnt1", 32'(grant_cnt1), 32'd2);
`endif

        // Bad addresses on port 1: unaligned, then outside the window
        $display("[TB] bad address");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h6);
        expectRead(1'b1, 32'h0, 1'b1);
        tick();
        checkOutput("badGnt1", 32'(gnt1), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("badErrUnaligned", 32'(err1), 32'h1);
        checkOutput("badRdata1", rdata1, 32'h0);
        checkOutput("badPort0Untouched", rdata0, rom[0]);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h80);
        expectRead(1'b1, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("badErrWindow", 32'(err1), 32'h1);
        tick();

        // Reset while busy: in-flight read dropped, no rvalid afterwards
        $display("[TB] mid-read reset");
        applyStimulus(1'b1, 32'h8, 1'b0, 32'h0);
        tick();
        checkOutput("midBusy", 32'(busy), 32'h1);
        #1 reset = 1'b1;
        #1;
        checkOutput("midRstPulses", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy}), 32'h0);
        checkOutput("midRstRdata0", rdata0, 32'h0);
        checkOutput("midRstRdata1", rdata1, 32'h0);
        checkOutput("midRstMemAddr", mem_addr, 32'h0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) tick();
        checkOutput("midNoRvalid", 32'(rvalid0 | rvalid1), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hC);
        expectRead(1'b1, rom[3], 1'b0);
        tick();
        checkOutput("afterRstGnt1", 32'(gnt1), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) tick();

        // Twenty back-to-back fetches; the grant counter saturates at 15
        $display("[TB] saturation");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'((i % 32) * 4), 1'b0, 32'h0);
            expectRead(1'b0, rom[i % 32], 1'b0);
            tick();
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        repeat (2) tick();
`ifdef ROM_ARB_STATS_EN
        checkOutput("grantCnt0Sat", 32'(grant_cnt0), 32'd15);
`endif
        checkOutput("sbDrained", 32'(sbq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
